// File: rtl/serial_pkg.sv
// Definitions shared by the serializer / serial_word_receiver pair.
// Both ends take their default word width from here so they stay in step.
package serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  localparam int SERIAL_WORD_W = 4;

endpackage

// File: rtl/serial_word_receiver_bit_counter.sv
// Modulo-N bit counter. A clear restarts the count; when en is high in the
// same cycle, the current bit is counted, so the count lands on 1 instead of 0.
module bit_counter #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = en ? CW'(1) : '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == LAST);

endmodule

// File: rtl/serial_word_receiver.sv
// Reassembles LSB-first serial bits framed by a sync strobe into N-bit words,
// with a one-deep valid/ready holding register and sticky overrun/framing flags.
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter  int N  = SERIAL_WORD_W,
  localparam int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sync,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         busy,
  output logic         overrun,
  output logic         frame_err,
  input  logic         clear_err
);

  rx_state_e      state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [N-1:0]   data_q, data_d;
  logic           dvalid_q, dvalid_d;
  logic           busy_q, busy_d;
  logic           overrun_q, overrun_d;
  logic           ferr_q, ferr_d;

  logic           in_recv;
  logic           start;
  logic           abort;
  logic           complete;
  logic           hold_free;
  logic [N-1:0]   word;
  logic           cnt_clr;
  logic           cnt_en;
  logic           cnt_tc;
  logic [CW-1:0]  cnt_unused;

  bit_counter #(.N(N)) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .count   (cnt_unused),
    .tc      (cnt_tc)
  );

  assign in_recv   = (state_q == RECV);
  assign start     = sin_valid && sync;
  assign abort     = in_recv && sin_valid && sync;
  assign complete  = in_recv && sin_valid && !sync && cnt_tc;
  assign hold_free = !dvalid_q || data_ready;
  assign word      = {sin, sr_q[N-1:1]};

  // A sync restarts the count at 1 (its own bit); completion returns it to 0.
  assign cnt_clr = start || complete;
  assign cnt_en  = sin_valid && (sync || in_recv) && !complete;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    data_d    = data_q;
    dvalid_d  = dvalid_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;

    if (start) begin
      state_d = RECV;
      sr_d    = {sin, {(N-1){1'b0}}};
    end else if (in_recv && sin_valid) begin
      sr_d = word;
      if (complete) begin
        state_d = IDLE;
      end
    end

    if (complete && hold_free) begin
      data_d   = word;
      dvalid_d = 1'b1;
    end else if (dvalid_q && data_ready) begin
      dvalid_d = 1'b0;
    end

    // Set events take precedence over a simultaneous clear.
    if (complete && !hold_free) begin
      overrun_d = 1'b1;
    end else if (clear_err) begin
      overrun_d = 1'b0;
    end

    if (abort) begin
      ferr_d = 1'b1;
    end else if (clear_err) begin
      ferr_d = 1'b0;
    end

    busy_d = (state_d == RECV);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      data_q    <= '0;
      dvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      dvalid_q  <= dvalid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dvalid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (N=4): a table of per-cycle input
// records with expected post-edge outputs, plus a hand-written async-reset sequence.
module tb_serial_word_receiver;

  logic       clk;
  logic       reset_n;
  logic       sin;
  logic       sin_valid;
  logic       sync;
  logic [3:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       overrun;
  logic       frame_err;
  logic       clear_err;

  int total;
  int bad;

  typedef struct {
    string      name;
    logic       sv;
    logic       s;
    logic       sy;
    logic       rdy;
    logic       clr;
    logic       dv;
    logic [3:0] dout;
    logic       bsy;
    logic       ov;
    logic       fe;
  } vec_t;

  vec_t vecs[$];

  serial_word_receiver #(.N(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sync       (sync),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .clear_err  (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic sv, logic s, logic sy, logic rdy, logic clr,
                              logic dv, logic [3:0] d, logic b, logic o, logic f);
    vec_t v;
    v.name = nm; v.sv = sv; v.s = s; v.sy = sy; v.rdy = rdy; v.clr = clr;
    v.dv = dv; v.dout = d; v.bsy = b; v.ov = o; v.fe = f;
    return v;
  endfunction

  task automatic check(string nm, logic dv, logic [3:0] d, logic b, logic o, logic f);
    total++;
    if (data_valid !== dv || data_out !== d || busy !== b || overrun !== o || frame_err !== f) begin
      bad++;
      $display("FAIL %s: got dv=%b dout=%b busy=%b ovr=%b ferr=%b, want dv=%b dout=%b busy=%b ovr=%b ferr=%b",
               nm, data_valid, data_out, busy, overrun, frame_err, dv, d, b, o, f);
    end
  endtask

  task automatic run_vec(vec_t v);
    sin_valid  = v.sv;
    sin        = v.s;
    sync       = v.sy;
    data_ready = v.rdy;
    clear_err  = v.clr;
    @(posedge clk);
    @(negedge clk);
    check(v.name, v.dv, v.dout, v.bsy, v.ov, v.fe);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; data_ready = 1'b0; clear_err = 1'b0;

    //                 name        sv s  sy rdy clr   dv dout     bsy ov fe
    // Basic word 1,1,0,1 -> 4'b1011, then drained.
    vecs.push_back(mk("basic0",    1, 1, 1, 1, 0,    0, 4'b0000, 1, 0, 0));
    vecs.push_back(mk("basic1",    1, 1, 0, 1, 0,    0, 4'b0000, 1, 0, 0));
    vecs.push_back(mk("basic2",    1, 0, 0, 1, 0,    0, 4'b0000, 1, 0, 0));
    vecs.push_back(mk("basic3",    1, 1, 0, 1, 0,    1, 4'b1011, 0, 0, 0));
    vecs.push_back(mk("basic_drn", 0, 0, 0, 1, 0,    0, 4'b1011, 0, 0, 0));
    // Unsynced bits in IDLE, sync without strobe: all ignored.
    vecs.push_back(mk("nosync0",   1, 1, 0, 1, 0,    0, 4'b1011, 0, 0, 0));
    vecs.push_back(mk("nosync1",   1, 0, 0, 1, 0,    0, 4'b1011, 0, 0, 0));
    vecs.push_back(mk("nosync2",   1, 1, 0, 1, 0,    0, 4'b1011, 0, 0, 0));
    vecs.push_back(mk("sync_nov",  0, 1, 1, 1, 0,    0, 4'b1011, 0, 0, 0));
    // Word 0,1,1,0 with 2-cycle strobe gaps -> 4'b0110, held with ready low.
    vecs.push_back(mk("gap_b0",    1, 0, 1, 0, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("gap_w0",    0, 1, 0, 0, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("gap_w1",    0, 0, 1, 0, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("gap_b1",    1, 1, 0, 0, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("gap_w2",    0, 0, 0, 0, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("gap_w3",    0, 0, 0, 0, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("gap_b2",    1, 1, 0, 0, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("gap_w4",    0, 0, 0, 0, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("gap_w5",    0, 0, 0, 0, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("gap_b3",    1, 0, 0, 0, 0,    1, 4'b0110, 0, 0, 0));
    vecs.push_back(mk("gap_hold",  0, 0, 0, 0, 0,    1, 4'b0110, 0, 0, 0));
    vecs.push_back(mk("gap_drn",   0, 0, 0, 1, 0,    0, 4'b0110, 0, 0, 0));
    // Overrun: 1011 held, 0001 dropped; clear; clear loses to a new overrun.
    vecs.push_back(mk("ov_a0",     1, 1, 1, 0, 0,    0, 4'b0110, 1, 0, 0));
    vecs.push_back(mk("ov_a1",     1, 1, 0, 0, 0,    0, 4'b0110, 1, 0, 0));
    vecs.push_back(mk("ov_a2",     1, 0, 0, 0, 0,    0, 4'b0110, 1, 0, 0));
    vecs.push_back(mk("ov_a3",     1, 1, 0, 0, 0,    1, 4'b1011, 0, 0, 0));
    vecs.push_back(mk("ov_b0",     1, 1, 1, 0, 0,    1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("ov_b1",     1, 0, 0, 0, 0,    1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("ov_b2",     1, 0, 0, 0, 0,    1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("ov_b3",     1, 0, 0, 0, 0,    1, 4'b1011, 0, 1, 0));
    vecs.push_back(mk("ov_clr",    0, 0, 0, 0, 1,    1, 4'b1011, 0, 0, 0));
    vecs.push_back(mk("ov_c0",     1, 1, 1, 0, 0,    1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("ov_c1",     1, 0, 0, 0, 0,    1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("ov_c2",     1, 0, 0, 0, 0,    1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("ov_setwin", 1, 0, 0, 0, 1,    1, 4'b1011, 0, 1, 0));
    vecs.push_back(mk("ov_clr2",   0, 0, 0, 0, 1,    1, 4'b1011, 0, 0, 0));
    // Back-to-back 4'hA then 4'h5; 4'h5 completes in the cycle 4'hA is taken.
    vecs.push_back(mk("b2b_drn",   0, 0, 0, 1, 0,    0, 4'b1011, 0, 0, 0));
    vecs.push_back(mk("b2b_a0",    1, 0, 1, 1, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("b2b_a1",    1, 1, 0, 1, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("b2b_a2",    1, 0, 0, 1, 0,    0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk("b2b_a3",    1, 1, 0, 1, 0,    1, 4'hA,    0, 0, 0));
    vecs.push_back(mk("b2b_50",    1, 1, 1, 0, 0,    1, 4'hA,    1, 0, 0));
    vecs.push_back(mk("b2b_51",    1, 0, 0, 0, 0,    1, 4'hA,    1, 0, 0));
    vecs.push_back(mk("b2b_52",    1, 1, 0, 0, 0,    1, 4'hA,    1, 0, 0));
    vecs.push_back(mk("b2b_53",    1, 0, 0, 1, 0,    1, 4'h5,    0, 0, 0));
    vecs.push_back(mk("b2b_drn2",  0, 0, 0, 1, 0,    0, 4'h5,    0, 0, 0));
    // Resync after 2 bits, then 1,0,0,1 -> 4'b1001.
    vecs.push_back(mk("rs_p0",     1, 1, 1, 1, 0,    0, 4'h5,    1, 0, 0));
    vecs.push_back(mk("rs_p1",     1, 1, 0, 1, 0,    0, 4'h5,    1, 0, 0));
    vecs.push_back(mk("rs_sync",   1, 1, 1, 1, 0,    0, 4'h5,    1, 0, 1));
    vecs.push_back(mk("rs_b1",     1, 0, 0, 1, 0,    0, 4'h5,    1, 0, 1));
    vecs.push_back(mk("rs_b2",     1, 0, 0, 1, 0,    0, 4'h5,    1, 0, 1));
    vecs.push_back(mk("rs_b3",     1, 1, 0, 1, 0,    1, 4'b1001, 0, 0, 1));
    vecs.push_back(mk("rs_clr",    0, 0, 0, 1, 1,    0, 4'b1001, 0, 0, 0));
    // Sync arriving on what would have been the 4th bit; then 1,0,0,0 -> 4'b0001.
    vecs.push_back(mk("rs4_p0",    1, 0, 1, 1, 0,    0, 4'b1001, 1, 0, 0));
    vecs.push_back(mk("rs4_p1",    1, 0, 0, 1, 0,    0, 4'b1001, 1, 0, 0));
    vecs.push_back(mk("rs4_p2",    1, 0, 0, 1, 0,    0, 4'b1001, 1, 0, 0));
    vecs.push_back(mk("rs4_sync",  1, 1, 1, 1, 0,    0, 4'b1001, 1, 0, 1));
    vecs.push_back(mk("rs4_b1",    1, 0, 0, 1, 0,    0, 4'b1001, 1, 0, 1));
    vecs.push_back(mk("rs4_b2",    1, 0, 0, 1, 0,    0, 4'b1001, 1, 0, 1));
    vecs.push_back(mk("rs4_b3",    1, 0, 0, 1, 0,    1, 4'b0001, 0, 0, 1));
    vecs.push_back(mk("rs4_clr",   0, 0, 0, 1, 1,    0, 4'b0001, 0, 0, 0));

    repeat (3) @(negedge clk);
    check("reset_in", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_out", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset with a held word and 2 bits in flight.
    run_vec(mk("ar_a0",    1, 1, 1, 0, 0,    0, 4'b0001, 1, 0, 0));
    run_vec(mk("ar_a1",    1, 1, 0, 0, 0,    0, 4'b0001, 1, 0, 0));
    run_vec(mk("ar_a2",    1, 0, 0, 0, 0,    0, 4'b0001, 1, 0, 0));
    run_vec(mk("ar_a3",    1, 1, 0, 0, 0,    1, 4'b1011, 0, 0, 0));
    run_vec(mk("ar_f0",    1, 0, 1, 0, 0,    1, 4'b1011, 1, 0, 0));
    run_vec(mk("ar_f1",    1, 1, 0, 0, 0,    1, 4'b1011, 1, 0, 0));
    sin_valid = 1'b0;
    sync      = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("ar_immediate", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("ar_held", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    run_vec(mk("ar_n0",    1, 0, 1, 1, 0,    0, 4'b0000, 1, 0, 0));
    run_vec(mk("ar_n1",    1, 1, 0, 1, 0,    0, 4'b0000, 1, 0, 0));
    run_vec(mk("ar_n2",    1, 1, 0, 1, 0,    0, 4'b0000, 1, 0, 0));
    run_vec(mk("ar_n3",    1, 0, 0, 1, 0,    1, 4'b0110, 0, 0, 0));
    run_vec(mk("ar_ndrn",  0, 0, 0, 1, 0,    0, 4'b0110, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
